// File: rtl/tbus_arbiter.sv
// Round-robin arbiter and select sequencer for a 4-source tristate bus.
// Settle cycle before each drive, dead turnaround cycles after it.
module tbus_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int TURN     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       s,
  output logic       t,
  output logic       oe,
  output logic [3:0] gnt,
  output logic       busy
);

  localparam int CMAX = (HOLD_MAX > TURN) ? HOLD_MAX : TURN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_GRANT,
    ST_TURN
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            oe_q, oe_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [1:0]      win;
  logic            hit;

  // First requester at or after the pointer, wrapping mod 4.
  always_comb begin
    win = ptr_q;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && req[ptr_q + 2'(i)]) begin
        hit = 1'b1;
        win = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    oe_d    = 1'b0;
    gnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_SETUP;
          own_d   = win;
        end
      end
      ST_SETUP: begin
        state_d = ST_GRANT;
        oe_d    = 1'b1;
        gnt_d   = 4'b0001 << own_q;
        cnt_d   = '0;
      end
      ST_GRANT: begin
        if (!req[own_q] || cnt_q == CW'(HOLD_MAX - 1)) begin
          state_d = ST_TURN;
          cnt_d   = '0;
          ptr_d   = own_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          oe_d  = 1'b1;
          gnt_d = gnt_q;
        end
      end
      ST_TURN: begin
        if (cnt_q == CW'(TURN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Owner only changes on the IDLE->SETUP edge, so selects never glitch.
  assign s    = own_q[0];
  assign t    = own_q[1];
  assign oe   = oe_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Bench for tbus_arbiter: two parameterisations share req/reset and
// are compared every cycle against a countdown-based reference model.
module tb_tbus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       s_w   [2];
  logic       t_w   [2];
  logic       oe_w  [2];
  logic [3:0] gnt_w [2];
  logic       busy_w[2];

  int errors = 0;
  int checks = 0;

  tbus_arbiter #(.HOLD_MAX(8), .TURN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .s(s_w[0]), .t(t_w[0]), .oe(oe_w[0]),
    .gnt(gnt_w[0]), .busy(busy_w[0])
  );

  tbus_arbiter #(.HOLD_MAX(2), .TURN(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .s(s_w[1]), .t(t_w[1]), .oe(oe_w[1]),
    .gnt(gnt_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner plus countdowns of setup/grant/dead cycles.
  int hmax [2] = '{8, 2};
  int tdead[2] = '{1, 3};
  int m_own[2], m_ptr[2], m_gcnt[2], m_tleft[2];
  bit m_setup[2], m_grant[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0; m_ptr[i] = 0; m_gcnt[i] = 0; m_tleft[i] = 0;
      m_setup[i] = 0; m_grant[i] = 0;
    end
  endtask

  task automatic mstep(input logic [3:0] r);
    for (int i = 0; i < 2; i++) begin
      if (m_grant[i]) begin
        m_gcnt[i]++;
        if (!r[m_own[i]] || m_gcnt[i] == hmax[i]) begin
          m_grant[i] = 0;
          m_tleft[i] = tdead[i];
          m_ptr[i]   = (m_own[i] + 1) % 4;
        end
      end else if (m_setup[i]) begin
        m_setup[i] = 0;
        m_grant[i] = 1;
        m_gcnt[i]  = 0;
      end else if (m_tleft[i] > 0) begin
        m_tleft[i]--;
      end else if (r != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (r[(m_ptr[i] + k) % 4]) m_own[i] = (m_ptr[i] + k) % 4;
        m_setup[i] = 1;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] eg;
      eg = m_grant[i] ? (4'b0001 << m_own[i]) : 4'b0000;
      chk($sformatf("gnt%0d", i), 32'(gnt_w[i]), 32'(eg));
      chk($sformatf("oe%0d", i), 32'(oe_w[i]), 32'(m_grant[i]));
      chk($sformatf("s%0d", i), 32'(s_w[i]), 32'(m_own[i] % 2));
      chk($sformatf("t%0d", i), 32'(t_w[i]), 32'(m_own[i] / 2));
      chk($sformatf("busy%0d", i), 32'(busy_w[i]),
          32'(m_setup[i] | m_grant[i] | (m_tleft[i] > 0)));
      chk($sformatf("onehot%0d", i), 32'($countones(gnt_w[i]) <= 1), 32'd1);
      chk($sformatf("oe_or%0d", i), 32'(oe_w[i]), 32'(|gnt_w[i]));
    end
  endtask

  task automatic zeros(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_oe"}, 32'(oe_w[i]), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt_w[i]), 32'd0);
      chk({tag, "_s"}, 32'(s_w[i]), 32'd0);
      chk({tag, "_t"}, 32'(t_w[i]), 32'd0);
      chk({tag, "_busy"}, 32'(busy_w[i]), 32'd0);
    end
  endtask

  task automatic run(input logic [3:0] r, input int n);
    for (int c = 0; c < n; c++) begin
      req = r;
      @(posedge clk);
      mstep(r);
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    logic [3:0] rr;
    rst_n = 1'b0;
    req   = 4'b0;
    mreset();
    @(negedge clk);
    zeros("reset");
    rst_n = 1'b1;
    run(4'b0000, 3);
    run(4'b0001, 30);
    run(4'b0000, 6);
    run(4'b1111, 50);
    run(4'b0000, 6);
    run(4'b0100, 3);
    run(4'b0000, 8);
    run(4'b0010, 4);
    run(4'b1010, 16);
    run(4'b0000, 6);
    run(4'b0010, 4);
    // Asynchronous reset between edges while a grant is active.
    req = 4'b0010;
    @(posedge clk);
    mstep(req);
    #2 rst_n = 1'b0;
    #1 zeros("async_rst");
    mreset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    run(4'b1000, 14);
    run(4'b0000, 6);
    rr = 4'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      run(rr, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-source tristate bus: four sources a, b, c, d feed one wire w through two tristate 2:1 muxes.
- Grants one requester at a time and drives the mux selects s (within a pair) and t (which pair drives).
- Inserts a select-settle cycle before every drive and dead turnaround cycles after it, so slow switch-level drivers never overlap.
- Sits between the four bus producers and the mux; the sink samples w only while oe=1.

Parameters:
HOLD_MAX, 8, max consecutive GRANT cycles per ownership (>=1)
TURN, 1, dead cycles with oe=0 after each ownership (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per source; bit k: 0=a, 1=b, 2=c, 3=d
s  output  1  mux pair-select; equals owner[0]
t  output  1  mux pair-enable; equals owner[1] (t=1 selects c/d)
oe  output  1  bus drive-valid qualifier for the sink
gnt  output  4  one-hot grant, registered
busy  output  1  1 in any state except IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- All outputs are registered. No combinational path from req to any output.
- Reset (async, any time, including mid-GRANT):
  - Outputs clear immediately: s=0, t=0, oe=0, gnt=0, busy=0.
  - state=IDLE, round-robin pointer ptr=0, hold counter=0.
- States: IDLE, SETUP, GRANT, TURN.
- IDLE:
  - oe=0, gnt=0.
  - If req!=0, the winner k is the first set bit searching ptr, ptr+1, ... mod 4.
  - Next edge: state=SETUP, s=k[0], t=k[1], owner=k.
  - If req==0, stay in IDLE.
- SETUP (exactly 1 cycle):
  - oe=0, gnt=0, s/t stable.
  - Next edge: state=GRANT, oe=1, gnt[owner]=1, counter=0.
  - req is not rechecked here. If the owner dropped req, it still gets at least 1 GRANT cycle.
- GRANT:
  - Counter increments each cycle.
  - Leave to TURN at the edge where req[owner]==0 is sampled, or where counter==HOLD_MAX-1, whichever comes first.
  - That edge: oe=0, gnt=0, ptr=(owner+1) mod 4.
  - Ownership lasts at most HOLD_MAX cycles.
  - Requests from other sources are ignored while in GRANT.
- TURN:
  - oe=0, gnt=0, s/t hold their last value (no select glitch).
  - After exactly TURN cycles, go to IDLE.
- Latency:
  - req sampled in IDLE -> gnt/oe high 2 edges later.
  - Minimum oe=0 gap between two ownerships = TURN+2 cycles (TURN, IDLE, SETUP).
- Invariants:
  - gnt is one-hot or zero.
  - oe==|gnt.
  - s/t change only on the IDLE->SETUP edge.
- Same source re-requesting after HOLD_MAX expiry:
  - Loses to any other active requester, since ptr has advanced.
  - If it is alone, it is re-granted after TURN+IDLE+SETUP.
- Simultaneous requests in IDLE: only the pointer order decides; no fixed priority after the first grant.

Test Plan:
- Reset then req=4'b0001 held: gnt=0001, oe=1 on the 2nd edge; s=0, t=0; after 8 GRANT cycles oe=0 for 1 cycle (TURN), then IDLE, SETUP, and re-grant to source 0.
- req=4'b1111 held continuously: grant order 0,1,2,3,0; each grant 8 cycles; between grants 3 cycles of oe=0; {t,s} follows 00,01,10,11.
- req=4'b0100 pulsed 3 cycles: SETUP then GRANT; gnt=0100 for the cycle(s) until the drop is sampled; t=1, s=0; oe falls on the sampling edge; back to IDLE after TURN; ptr=3.
- During GRANT to source 1, raise req[3]: gnt stays 0010, s/t unchanged; source 3 is granted only after TURN+IDLE+SETUP.
- Assert rst_n=0 asynchronously mid-GRANT (between edges): oe, gnt, s, t, busy clear with no clock; after release with req=4'b1000, source 3 is granted via ptr search from 0.
- With TURN=3 and HOLD_MAX=2: per ownership, oe=1 for exactly 2 cycles and oe=0 for exactly 5 cycles between back-to-back grants; check gnt one-hot and oe==|gnt on every cycle.
